bus_initiator: RTL and testbench

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator_if.sv | 28 ++
 rtl/bus_initiator.sv | 104 ++++++++++
 tb/tb_bus_initiator.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_initiator_if.sv
// bus_initiator_if: command, bus and response signals of the bus initiator
interface bus_initiator_if #(
    parameter int ADDR_W = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_be;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_len;
    logic              bus_en;
    logic [3:0]        bus_we;
    logic [31:0]       bus_addr;
    logic [31:0]       bus_dout;
    logic [31:0]       bus_din;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              wr_done;
    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_be, cmd_wdata, cmd_len, bus_din,
        output cmd_ready, bus_en, bus_we, bus_addr, bus_dout, rsp_valid, rsp_data, wr_done
    );
    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_be, cmd_wdata, cmd_len, bus_din,
        input  cmd_ready, bus_en, bus_we, bus_addr, bus_dout, rsp_valid, rsp_data, wr_done
    );
endinterface

// File: rtl/bus_initiator.sv
// bus_initiator: single-command bus master with fixed-latency reads; define BUS_INITIATOR_BURST_EN for cmd_len+1 beat bursts
module bus_initiator #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 12
) (
    input logic             io_clk,
    input logic             io_rst,
    bus_initiator_if.master bus
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_we;
    logic [31:0]       r_dout;
    logic [31:0]       r_rdata;
    logic              r_en;
    logic              r_rsp;
    logic              r_done;
    logic [2:0]        r_wait;
    logic              w_last;
    logic              w_unused;
`ifdef BUS_INITIATOR_BURST_EN
    logic [3:0]        r_cnt;
    assign w_last = r_cnt == 4'd0;
    // remaining beats: loaded from cmd_len at acceptance, stepped at each beat boundary
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) r_cnt <= '0;
        else if (bus.cmd_valid && bus.cmd_ready) r_cnt <= bus.cmd_len;
        else if ((r_state == WRITE || r_state == RESP) && !w_last) r_cnt <= r_cnt - 4'd1;
    end
`else
    assign w_last = 1'b1;
`endif
    assign w_unused      = ^{bus.cmd_len, bus.cmd_addr[1:0]};
    assign bus.cmd_ready = (r_state == IDLE) && !io_rst;
    assign bus.bus_en    = r_en;
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = 32'(r_addr);
    assign bus.bus_dout  = r_dout;
    assign bus.rsp_valid = r_rsp;
    assign bus.rsp_data  = r_rdata;
    assign bus.wr_done   = r_done;
    // command FSM; bus strobes and pulses are registered so each is valid for exactly its state's cycle
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_we    <= '0;
            r_dout  <= '0;
            r_rdata <= '0;
            r_en    <= 1'b0;
            r_rsp   <= 1'b0;
            r_done  <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_rsp  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.cmd_valid) begin
                    r_en   <= 1'b1;
                    r_addr <= {bus.cmd_addr[ADDR_W-1:2], 2'b00};
                    if (bus.cmd_wr) begin
                        r_state <= WRITE;
                        r_we    <= bus.cmd_be;
                        r_dout  <= bus.cmd_wdata;
                    end else begin
                        r_state <= READ;
                        r_we    <= '0;
                    end
                end
                WRITE: if (w_last) begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                    r_we    <= '0;
                    r_done  <= 1'b1;
                end else begin
                    r_addr <= r_addr + STEP;
                end
                READ: begin
                    r_en    <= 1'b0;
                    r_wait  <= 3'd1;
                    r_state <= (RD_LAT == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    r_wait <= r_wait + 3'd1;
                    if (r_wait == 3'(RD_LAT - 1)) r_state <= RESP;
                end
                RESP: begin
                    r_rdata <= bus.bus_din;
                    r_rsp   <= 1'b1;
                    if (w_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= READ;
                        r_en    <= 1'b1;
                        r_addr  <= r_addr + STEP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: randomized self-checking bench for bus_initiator against a transaction-level model
module tb_bus_initiator;
    localparam int RD_LAT = 2;
    localparam int ADDR_W = 12;
    typedef struct {int c; logic [3:0] we; logic [31:0] addr; logic [31:0] dout;} strobe_t;
    logic io_clk = 1'b0;
    logic io_rst = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] last_dout = '0;
    strobe_t strobes[$];
    int rsp_cyc[$];
    logic [31:0] rsp_dat[$];
    int done_cyc[$];
    int due_c[$];
    logic [31:0] due_a[$];
    bus_initiator_if #(.ADDR_W(ADDR_W)) bus();
    bus_initiator #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (.io_clk(io_clk), .io_rst(io_rst), .bus(bus));
    always #5 io_clk = ~io_clk;
    always @(posedge io_clk) cyc <= cyc + 1;
    function automatic int beats(input logic [3:0] len);
`ifdef BUS_INITIATOR_BURST_EN
        return int'(len) + 1;
`else
        return 1;
`endif
    endfunction
    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
        return ((base & 32'hFFC) + 32'(4 * k)) % 32'd4096;
    endfunction
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h020) ? 32'h12345678 : {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction
    function automatic void clear_logs();
        strobes.delete(); rsp_cyc.delete(); rsp_dat.delete(); done_cyc.delete();
    endfunction
    // monitor on the falling edge, plus a responder that presents data only RD_LAT cycles after a read strobe
    always @(negedge io_clk) begin
        if (bus.bus_en) begin
            strobes.push_back('{cyc, bus.bus_we, bus.bus_addr, bus.bus_dout});
            due_c.push_back(cyc + RD_LAT);
            due_a.push_back(bus.bus_addr);
        end
        if (bus.rsp_valid) begin rsp_cyc.push_back(cyc); rsp_dat.push_back(bus.rsp_data); end
        if (bus.wr_done) done_cyc.push_back(cyc);
        while (due_c.size() > 0 && due_c[0] < cyc) begin void'(due_c.pop_front()); void'(due_a.pop_front()); end
        if (due_c.size() > 0 && due_c[0] == cyc) bus.bus_din = mem(due_a[0]);
        else bus.bus_din = $urandom;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
    task automatic drive(input logic wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data, input logic [3:0] len);
        bus.cmd_wr = wr; bus.cmd_addr = addr[ADDR_W-1:0]; bus.cmd_be = be; bus.cmd_wdata = data; bus.cmd_len = len;
    endtask
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data, input logic [3:0] len, output int a);
        @(posedge io_clk); #1;
        drive(wr, addr, be, data, len);
        bus.cmd_valid = 1'b1;
        a = -1;
        for (int i = 0; i < 100 && a < 0; i++) begin @(negedge io_clk); if (bus.cmd_ready) a = cyc; end
        checks++;
        if (a < 0) begin failures++; $display("FAIL accept: got no cmd_ready, expected acceptance within 100 cycles"); end
        @(posedge io_clk); #1;
        bus.cmd_valid = 1'b0;
        drive($urandom, $urandom, $urandom, $urandom, $urandom);
    endtask
    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        #2 io_rst = 1'b1;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.bus_en, bus.bus_we, bus.bus_addr, bus.bus_dout, bus.rsp_valid, bus.rsp_data, bus.wr_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b en=%b we=%h addr=%h dout=%h rv=%b rd=%h done=%b, expected all 0",
                bus.cmd_ready, bus.bus_en, bus.bus_we, bus.bus_addr, bus.bus_dout, bus.rsp_valid, bus.rsp_data, bus.wr_done);
        end
        repeat (3) @(posedge io_clk);
        #1 io_rst = 1'b0;
        @(negedge io_clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b expected 1", bus.cmd_ready); end
    endtask
    task automatic test_write(input int iters);
        logic [31:0] base, data;
        logic [3:0] be, len;
        int a, n;
        for (int it = 0; it < iters; it++) begin
            base = (it == 0) ? 32'h010 : (it == 2) ? 32'hFF8 : $urandom_range(0, 4095);
            be   = (it == 0) ? 4'hF : (it == 1) ? 4'h0 : 4'($urandom);
            data = (it == 0) ? 32'hDEADBEEF : $urandom;
            len  = (it == 0) ? 4'd7 : (it == 2) ? 4'd3 : 4'($urandom);
            n = beats(len);
            clear_logs();
            issue(1'b1, base, be, data, len, a);
            repeat (n + 3) @(negedge io_clk);
            checks++;
            if (strobes.size() != n) begin failures++; $display("FAIL wr_beats[%0d]: got %0d expected %0d", it, strobes.size(), n); end
            for (int k = 0; k < n && k < strobes.size(); k++) begin
                checks++;
                if (strobes[k].c != a + 1 + k || strobes[k].we !== be || strobes[k].addr !== exp_addr(base, k) || strobes[k].dout !== data) begin
                    failures++;
                    $display("FAIL wr_beat[%0d.%0d]: got cyc=%0d we=%h addr=%h dout=%h expected cyc=%0d we=%h addr=%h dout=%h",
                        it, k, strobes[k].c, strobes[k].we, strobes[k].addr, strobes[k].dout, a + 1 + k, be, exp_addr(base, k), data);
                end
            end
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] != a + n + 1) begin
                failures++;
                $display("FAIL wr_done[%0d]: got %0d pulses first at %0d expected 1 at %0d", it, done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, a + n + 1);
            end
            checks++;
            if (bus.bus_en !== 1'b0 || bus.bus_we !== 4'h0 || bus.bus_addr !== exp_addr(base, n - 1) || bus.bus_dout !== data || rsp_cyc.size() != 0) begin
                failures++;
                $display("FAIL wr_hold[%0d]: got en=%b we=%h addr=%h dout=%h rsp=%0d expected 0 0 %h %h 0",
                    it, bus.bus_en, bus.bus_we, bus.bus_addr, bus.bus_dout, rsp_cyc.size(), exp_addr(base, n - 1), data);
            end
            last_dout = data;
        end
    endtask
    task automatic test_read(input int iters);
        logic [31:0] base;
        logic [3:0] len;
        int a, n, rc;
        for (int it = 0; it < iters; it++) begin
            base = (it == 0) ? 32'h020 : (it == 1) ? 32'hFF8 : $urandom_range(0, 4095);
            len  = (it == 0) ? 4'd0 : (it == 1) ? 4'd3 : 4'($urandom_range(0, 5));
            n = beats(len);
            clear_logs();
            issue(1'b0, base, $urandom, $urandom, len, a);
            repeat (n * (RD_LAT + 1) + 3) @(negedge io_clk);
            checks++;
            if (strobes.size() != n || rsp_cyc.size() != n) begin
                failures++;
                $display("FAIL rd_count[%0d]: got strobes=%0d rsp=%0d expected %0d each", it, strobes.size(), rsp_cyc.size(), n);
            end
            for (int k = 0; k < n && k < strobes.size() && k < rsp_cyc.size(); k++) begin
                rc = a + 1 + k * (RD_LAT + 1);
                checks++;
                if (strobes[k].c != rc || strobes[k].we !== 4'h0 || strobes[k].addr !== exp_addr(base, k)) begin
                    failures++;
                    $display("FAIL rd_strobe[%0d.%0d]: got cyc=%0d we=%h addr=%h expected cyc=%0d we=0 addr=%h",
                        it, k, strobes[k].c, strobes[k].we, strobes[k].addr, rc, exp_addr(base, k));
                end
                checks++;
                if (rsp_cyc[k] != rc + RD_LAT + 1 || rsp_dat[k] !== mem(exp_addr(base, k))) begin
                    failures++;
                    $display("FAIL rd_rsp[%0d.%0d]: got cyc=%0d data=%h expected cyc=%0d data=%h",
                        it, k, rsp_cyc[k], rsp_dat[k], rc + RD_LAT + 1, mem(exp_addr(base, k)));
                end
            end
            checks++;
            if (bus.bus_en !== 1'b0 || bus.bus_addr !== exp_addr(base, n - 1) || bus.bus_dout !== last_dout || bus.rsp_data !== mem(exp_addr(base, n - 1)) || done_cyc.size() != 0) begin
                failures++;
                $display("FAIL rd_hold[%0d]: got en=%b addr=%h dout=%h rd=%h done=%0d expected 0 %h %h %h 0",
                    it, bus.bus_en, bus.bus_addr, bus.bus_dout, bus.rsp_data, done_cyc.size(), exp_addr(base, n - 1), last_dout, mem(exp_addr(base, n - 1)));
            end
        end
    endtask
    task automatic test_busy();
        logic [31:0] aa, ad, ba, bd, ea, ed;
        logic [3:0] abe, bbe, al, bl, ew;
        int a, b, na, nb, ec;
        aa = $urandom_range(0, 4095); ad = $urandom; abe = 4'($urandom); al = 4'($urandom_range(0, 3));
        ba = $urandom_range(0, 4095); bd = $urandom; bbe = 4'($urandom); bl = 4'($urandom_range(0, 3));
        na = beats(al); nb = beats(bl);
        clear_logs();
        @(posedge io_clk); #1;
        drive(1'b1, aa, abe, ad, al);
        bus.cmd_valid = 1'b1;
        a = -1;
        for (int i = 0; i < 100 && a < 0; i++) begin @(negedge io_clk); if (bus.cmd_ready) a = cyc; end
        @(posedge io_clk); #1;
        drive(1'b1, ba, bbe, bd, bl);
        b = -1;
        for (int i = 0; i < 100 && b < 0; i++) begin @(negedge io_clk); if (bus.cmd_ready) b = cyc; end
        @(posedge io_clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (nb + 3) @(negedge io_clk);
        checks++;
        if (a < 0 || b != a + na + 1) begin failures++; $display("FAIL busy_accept: got first=%0d second=%0d expected second=%0d", a, b, a + na + 1); end
        checks++;
        if (strobes.size() != na + nb) begin failures++; $display("FAIL busy_beats: got %0d expected %0d", strobes.size(), na + nb); end
        for (int k = 0; k < na + nb && k < strobes.size(); k++) begin
            ec = (k < na) ? a + 1 + k : b + 1 + k - na;
            ea = (k < na) ? exp_addr(aa, k) : exp_addr(ba, k - na);
            ed = (k < na) ? ad : bd;
            ew = (k < na) ? abe : bbe;
            checks++;
            if (strobes[k].c != ec || strobes[k].we !== ew || strobes[k].addr !== ea || strobes[k].dout !== ed) begin
                failures++;
                $display("FAIL busy_beat[%0d]: got cyc=%0d we=%h addr=%h dout=%h expected cyc=%0d we=%h addr=%h dout=%h",
                    k, strobes[k].c, strobes[k].we, strobes[k].addr, strobes[k].dout, ec, ew, ea, ed);
            end
        end
        checks++;
        if (done_cyc.size() != 2 || done_cyc[0] != a + na + 1 || done_cyc[1] != b + nb + 1) begin
            failures++;
            $display("FAIL busy_done: got %0d pulses expected 2 at %0d and %0d", done_cyc.size(), a + na + 1, b + nb + 1);
        end
        last_dout = bd;
    endtask
    task automatic test_mid_reset(input logic wr);
        int a;
        issue(wr, 32'h100 + $urandom_range(0, 255), 4'hF, $urandom, 4'd3, a);
        if (!wr) begin @(posedge io_clk); #1; end
        io_rst = 1'b1;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.bus_en, bus.bus_we, bus.bus_addr, bus.bus_dout, bus.rsp_valid, bus.rsp_data, bus.wr_done} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs[wr=%b]: got ready=%b en=%b we=%h addr=%h dout=%h rv=%b rd=%h done=%b, expected all 0",
                wr, bus.cmd_ready, bus.bus_en, bus.bus_we, bus.bus_addr, bus.bus_dout, bus.rsp_valid, bus.rsp_data, bus.wr_done);
        end
        repeat (2) @(posedge io_clk);
        #1 io_rst = 1'b0;
        clear_logs();
        @(negedge io_clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready[wr=%b]: got %b expected 1", wr, bus.cmd_ready); end
        repeat (10) @(negedge io_clk);
        checks++;
        if (strobes.size() != 0 || rsp_cyc.size() != 0 || done_cyc.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_quiet[wr=%b]: got strobes=%0d rsp=%0d done=%0d expected 0 0 0", wr, strobes.size(), rsp_cyc.size(), done_cyc.size());
        end
        last_dout = '0;
    endtask
    initial begin
        test_reset();
        test_write(8);
        test_read(6);
        test_busy();
        test_mid_reset(1'b0);
        test_read(2);
        test_mid_reset(1'b1);
        test_write(3);
        test_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
